// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and helpers for the sequential binary-to-BCD converter.
//   state_t    - converter FSM states
//   min_digits - smallest digit count D with 10^D > 2^n
//   count_sig  - significant-digit count of a packed BCD word (minimum 1)
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest supported operand is 64 bits, and 2^64 has 20 decimal digits.
  localparam int MAX_DIGITS = 20;
  localparam int MAX_BCD_W  = 4 * MAX_DIGITS;

  // Counting the digits of 2^n-1 gives the smallest D with 10^D >= 2^n.
  // 2^n is never a power of ten, so that D also gives 10^D > 2^n.
  function automatic int min_digits(input int n);
    logic [63:0] x;
    int          d;
    x = (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
    d = 1;
    while (x >= 64'd10) begin
      x = x / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

  function automatic int count_sig(input logic [MAX_BCD_W-1:0] b, input int digits);
    int r;
    r = 1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits && b[4*i +: 4] != 4'd0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble correction cell. It adds 3 (mod 16) to a BCD digit
// that is >= 5, so that the following left shift carries correctly into the next digit.
//   din  - digit before correction
//   dout - digit after correction
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: sequential double-dabble converter. It runs one shift-and-add-3
// iteration per clock.
// Optional feature: define SIGNED_INPUT_EN to treat in_data as two's complement.
//   clk, reset          - clock, asynchronous active-high reset
//   in_valid/in_ready   - operand handshake, in_data is the N-bit operand
//   out_valid/out_ready - result handshake
//   bcd                 - packed BCD result, digit 0 in bits [3:0]
//   ndigits             - significant digits (value 0 gives 1)
//   neg                 - operand was negative (always 0 in the unsigned build)
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// CONV  | one shift-and-add-3 step per clock, N steps in total
// DONE  | result held on bcd/ndigits/neg until out_ready
module binary_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int N      = 32,
  parameter int DIGITS = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*DIGITS-1:0]          bcd,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits,
  output logic                         neg
);

  localparam int CW  = $clog2(N+1);
  localparam int NDW = $clog2(DIGITS+1);
  localparam int BW  = 4 * DIGITS;
  localparam int SW  = BW + N;

  if (N < 4 || N > 64) begin : g_bad_n
    $error("binary_to_bcd_seq: N must be in 4..64");
  end
  if (DIGITS < min_digits(N) || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("binary_to_bcd_seq: DIGITS too small for N (need 10^DIGITS > 2^N) or too large");
  end

  state_t          state_q, state_d;
  logic            load;
  logic [CW-1:0]   cnt_q;
  logic [SW-1:0]   sr_q;
  logic [SW-1:0]   sr_shift;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_final;
  logic [N-1:0]    mag;
  logic [BW-1:0]   bcd_q;
  logic [NDW-1:0]  nd_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (sr_q[N + 4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  assign sr_shift  = {bcd_adj, sr_q[N-1:0]} << 1;
  assign bcd_final = sr_shift[SW-1 -: BW];

`ifdef SIGNED_INPUT_EN
  logic neg_pend;
  logic neg_q;
  // The most negative value negates to 2^(N-1), which still fits as an unsigned N-bit magnitude.
  assign mag = in_data[N-1] ? (~in_data + {{(N-1){1'b0}}, 1'b1}) : in_data;
  assign neg = neg_q;
`else
  assign mag = in_data;
  assign neg = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load    = 1'b1;
            state_d = CONV;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      nd_q     <= NDW'(1);
`ifdef SIGNED_INPUT_EN
      neg_pend <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else if (load) begin
      sr_q     <= {{BW{1'b0}}, mag};
      cnt_q    <= CW'(N);
`ifdef SIGNED_INPUT_EN
      neg_pend <= in_data[N-1];
`endif
    end else if (state_q == CONV) begin
      sr_q  <= sr_shift;
      cnt_q <= cnt_q - CW'(1);
      // Result registers change only on the step that enters DONE, so they hold through DONE.
      if (cnt_q == CW'(1)) begin
        bcd_q <= bcd_final;
        nd_q  <= NDW'(count_sig(MAX_BCD_W'(bcd_final), DIGITS));
`ifdef SIGNED_INPUT_EN
        neg_q <= neg_pend;
`endif
      end
    end
  end

  assign bcd     = bcd_q;
  assign ndigits = nd_q;

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: directed checks of the sequential binary-to-BCD converter (N=32, DIGITS=10).
module tb_binary_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] bcd;
  logic [3:0]  ndigits;
  logic        neg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  binary_to_bcd_seq #(.N(32), .DIGITS(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd       (bcd),
    .ndigits   (ndigits),
    .neg       (neg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] v);
    int tmo;
    in_data  = v;
    in_valid = 1'b1;
    tmo = 0;
    while (!in_ready && tmo < 200) begin
      @(posedge clk); #1;
      tmo++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consumed", out_valid, 0);
  endtask

  task automatic conv_check(input string tag, input logic [31:0] v, input logic [39:0] exp_bcd,
                            input int exp_nd, input logic exp_neg);
    int e;
    send(v);
    wait_valid(e);
    chk({tag, "_latency"}, e, 32);
    chk({tag, "_bcd"}, bcd, exp_bcd);
    chk({tag, "_ndigits"}, ndigits, exp_nd);
    chk({tag, "_neg"}, neg, exp_neg);
    consume();
  endtask

  initial begin
    int e;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_ndigits", ndigits, 1);
    chk("rst_neg", neg, 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    conv_check("zero", 32'd0, 40'h0, 1, 1'b0);

`ifndef SIGNED_INPUT_EN
    conv_check("max", 32'hFFFF_FFFF, 40'h42_9496_7295, 10, 1'b0);
`endif

    // Back-to-back through DONE with out_ready held high.
    out_ready = 1'b1;
    send(32'd12345);
    wait_valid(e);
    chk("b2b1_latency", e, 32);
    chk("b2b1_bcd", bcd, 40'h12345);
    chk("b2b1_ndigits", ndigits, 5);
    in_data  = 32'd99;
    in_valid = 1'b1;
    chk("b2b_handoff_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    chk("b2b_handoff_valid", out_valid, 0);
    wait_valid(e);
    chk("b2b2_latency", e, 32);
    chk("b2b2_bcd", bcd, 40'h99);
    chk("b2b2_ndigits", ndigits, 2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_done", out_valid, 0);

    // Backpressure: result must hold while out_ready is low.
    send(32'd907);
    wait_valid(e);
    chk("bp_latency", e, 32);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_bcd", bcd, 40'h907);
      chk("bp_ndigits", ndigits, 3);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_accepted", out_valid, 0);

    // Reset in the middle of a conversion.
    send(32'd55555);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_bcd", bcd, 0);
    chk("midrst_ndigits", ndigits, 1);
    chk("midrst_in_ready", in_ready, 1);
    conv_check("after_rst", 32'd7, 40'h7, 1, 1'b0);

`ifdef SIGNED_INPUT_EN
    conv_check("s_min", 32'h8000_0000, 40'h21_4748_3648, 10, 1'b1);
    conv_check("s_m1", 32'hFFFF_FFFF, 40'h1, 1, 1'b1);
    conv_check("s_5", 32'd5, 40'h5, 1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_seq.md
# binary_to_bcd_seq

Sequential, parametrised binary-to-BCD converter for the calculator output unit. It accepts an N-bit binary operand over a valid/ready handshake and runs one shift-and-add-3 (double-dabble) iteration per clock. It then presents a packed BCD result, with a significant-digit count, to the display driver over a second valid/ready handshake. It replaces the purely combinational converter where the adder chain is too deep for timing at wide N.

## Interface
- N, 32: binary input width, 4 to 64.
- DIGITS, 10: BCD digits produced. It must satisfy 10^DIGITS > 2^N; an elaboration-time check fails otherwise.
- CW, $clog2(N+1): iteration counter width (localparam).
- clk  input  1: single clock; all state on rising edge.
- reset  input  1: asynchronous, active-high reset.
- in_valid  input  1: operand valid.
- in_ready  output  1: converter can accept an operand.
- in_data  input  N: binary operand.
- out_valid  output  1: result valid.
- out_ready  input  1: consumer accepts result.
- bcd  output  4*DIGITS: packed BCD; digit 0 in bits [3:0].
- ndigits  output  $clog2(DIGITS+1): significant digits; value 0 yields 1.
- neg  output  1: operand was negative (see Configuration).

## Operation
- FSM states are IDLE, CONV and DONE.
- IDLE
  - in_ready=1.
  - On in_valid: load the shift register {BCD=0, BIN=magnitude(in_data)}, set cnt=N, go to CONV.
- CONV
  - in_ready=0, out_valid=0.
  - Each cycle, every digit ≥5 gets +3 (mod 16), then the whole {BCD,BIN} register shifts left 1.
  - cnt decrements; on cnt==1 go to DONE.
- DONE
  - out_valid=1. bcd, ndigits and neg are stable until the handshake completes.
  - On out_ready: if in_valid is also high, load the new operand and go to CONV (back-to-back); otherwise go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- ndigits = index of the highest nonzero digit + 1, with a minimum of 1. It is registered on entry to DONE.
- in_data is sampled only at the accepting edge. Later changes are ignored.
- in_valid in CONV is ignored; no operand is lost because in_ready=0.
- Reset
  - Reset at any time, including mid-CONV, forces IDLE and abandons the conversion.
  - Reset values: bcd=0, ndigits=1, neg=0, out_valid=0, in_ready=1 once reset deasserts.

## Timing
- Latency: out_valid is high N clock edges after the accepting edge. For N=32 this is 32 edges.
- Throughput:
  - With out_ready held high, one result per N+1 cycles (back-to-back through DONE).
  - With a return via IDLE, N+2 cycles per result.
- Backpressure: out_valid, bcd, ndigits and neg are held indefinitely while out_ready=0.
- No combinational path from in_valid to out_valid or out_ready to bcd. in_ready depends combinationally on out_ready in DONE only.

## Configuration
- SIGNED_INPUT_EN defined:
  - in_data is two's complement; magnitude = |in_data|, computed at load; neg = in_data[N-1].
  - -2^(N-1) converts to magnitude 2^(N-1), which fits in N unsigned bits.
- SIGNED_INPUT_EN undefined:
  - in_data is unsigned; neg is tied 0.
  - The negation logic is not built.

## Structure
- Package bcd_pkg holds:
  - the state enum (IDLE/CONV/DONE);
  - a function that gives the minimum DIGITS for N;
  - a function that counts significant digits.
- Sub-module bcd_digit_adj is combinational, 4-bit in and 4-bit out, and adds 3 when the input is ≥5. It is instantiated DIGITS times via generate.
- The top level contains the FSM, counter, shift register and output registers.

## Test plan
- Reset, then in_data=0: bcd=0, ndigits=1, out_valid after 32 edges.
- in_data=32'hFFFFFFFF: bcd=BCD 4294967295, ndigits=10, out_valid exactly 32 edges after acceptance.
- out_ready held high, operands 12345 then 99 offered back-to-back:
  - results 12345 (ndigits 5) then 99 (ndigits 2);
  - second accepted in the DONE handoff cycle; no idle gap.
- out_ready low for 5 cycles after result 907:
  - bcd/ndigits stable, in_ready=0 throughout;
  - accepted on the first out_ready=1.
- reset asserted 10 cycles into the conversion of 55555:
  - out_valid=0, bcd=0, in_ready=1 after release;
  - next operand 7 yields 7.
- SIGNED_INPUT_EN defined:
  - 32'h80000000 yields neg=1, bcd=2147483648;
  - 32'hFFFFFFFF yields neg=1, bcd=1;
  - 5 yields neg=0, bcd=5.
